// File: rtl/decode_stage.sv
// ID stage: register bank, operand read, immediate sign-extension and a registered ID/EX boundary.
// Optional feature: define DECODE_WB_BYPASS_EN for write-back forwarding into captured/held operands.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_if,
    output logic            ready_id,
    input  logic [31:0]     NPC_if,
    input  logic [31:0]     IR_if,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            valid_id,
    input  logic            ready_ex,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [XLEN-1:0] Imm,
    output logic [31:0]     NPC_id,
    output logic [31:0]     IR_id
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    logic            valid_id_q, valid_id_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [31:0]     npc_q, npc_d;
    logic [31:0]     ir_q, ir_d;

    logic [IW-1:0]   rs1_idx, rs2_idx, wb_idx;
    logic [XLEN-1:0] rd_a, rd_b, imm_ext;
    logic            wb_write;

    // Field indices alias onto the low bits when NREG < 32.
    assign rs1_idx  = IR_if[16 +: IW];
    assign rs2_idx  = IR_if[11 +: IW];
    assign wb_idx   = wb_rd[IW-1:0];
    assign wb_write = wb_en && (wb_idx != '0);

    generate
        if (XLEN > 16) begin : g_sext
            assign imm_ext = {{(XLEN-16){IR_if[15]}}, IR_if[15:0]};
        end else begin : g_noext
            assign imm_ext = IR_if[XLEN-1:0];
        end
    endgenerate

    always_comb begin
        regs_d = regs_q;
        if (wb_write) begin
            regs_d[wb_idx] = wb_data;
        end
    end

    always_comb begin
        rd_a = (rs1_idx == '0) ? '0 : regs_q[rs1_idx];
        rd_b = (rs2_idx == '0) ? '0 : regs_q[rs2_idx];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_write && (wb_idx == rs1_idx)) rd_a = wb_data;
        if (wb_write && (wb_idx == rs2_idx)) rd_b = wb_data;
`endif
    end

    // Handshake: IF/ID transfers on an edge where ready_id is high and flush is low;
    // ID/EX transfers on an edge where valid_id && ready_ex. Flush invalidates ID/EX unconditionally.
    assign ready_id = !valid_id_q || ready_ex;

    always_comb begin
        valid_id_d = valid_id_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        npc_d      = npc_q;
        ir_d       = ir_q;
        if (flush) begin
            valid_id_d = 1'b0;
        end else if (ready_id) begin
            valid_id_d = valid_if;
            a_d        = rd_a;
            b_d        = rd_b;
            imm_d      = imm_ext;
            npc_d      = NPC_if;
            ir_d       = IR_if;
        end
`ifdef DECODE_WB_BYPASS_EN
        else begin
            // Held operands track write-back to the registers they were read from.
            if (wb_write && (wb_idx == ir_q[16 +: IW])) a_d = wb_data;
            if (wb_write && (wb_idx == ir_q[11 +: IW])) b_d = wb_data;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            valid_id_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            npc_q      <= '0;
            ir_q       <= '0;
        end else begin
            regs_q     <= regs_d;
            valid_id_q <= valid_id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            imm_q      <= imm_d;
            npc_q      <= npc_d;
            ir_q       <= ir_d;
        end
    end

    assign valid_id = valid_id_q;
    assign A        = a_q;
    assign B        = b_q;
    assign Imm      = imm_q;
    assign NPC_id   = npc_q;
    assign IR_id    = ir_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (XLEN=32, NREG=32); expectations follow DECODE_WB_BYPASS_EN if defined.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_if = 1'b0;
    logic        ready_id;
    logic [31:0] NPC_if = '0;
    logic [31:0] IR_if = '0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        valid_id;
    logic        ready_ex = 1'b1;
    logic [31:0] A, B, Imm, NPC_id, IR_id;

    int n_checks = 0;
    int n_fail   = 0;

    decode_stage #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_if(valid_if), .ready_id(ready_id),
        .NPC_if(NPC_if), .IR_if(IR_if), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .valid_id(valid_id), .ready_ex(ready_ex), .A(A), .B(B),
        .Imm(Imm), .NPC_id(NPC_id), .IR_id(IR_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_ir(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        wb_en = 1'b1; wb_rd = rd; wb_data = data;
        step();
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", valid_id); end
        n_checks++; if (A !== 32'h0) begin n_fail++; $display("FAIL reset_A: got %h exp 0", A); end
        n_checks++; if (IR_id !== 32'h0) begin n_fail++; $display("FAIL reset_IR: got %h exp 0", IR_id); end
        n_checks++; if (ready_id !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", ready_id); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_wb_read();
        wb_write(5'd3, 32'h1234);
        wb_write(5'd5, 32'h55);
        valid_if = 1'b1; IR_if = mk_ir(6'h01, 5'd1, 5'd3, 16'h0000); NPC_if = 32'h100;
        step();
        n_checks++; if (valid_id !== 1'b1) begin n_fail++; $display("FAIL wb_read_valid: got %b exp 1", valid_id); end
        n_checks++; if (A !== 32'h1234) begin n_fail++; $display("FAIL wb_read_A: got %h exp 1234", A); end
        n_checks++; if (B !== 32'h0) begin n_fail++; $display("FAIL wb_read_B: got %h exp 0", B); end
        n_checks++; if (NPC_id !== 32'h100) begin n_fail++; $display("FAIL wb_read_NPC: got %h exp 100", NPC_id); end
        n_checks++; if (IR_id !== 32'h04230000) begin n_fail++; $display("FAIL wb_read_IR: got %h exp 04230000", IR_id); end
        valid_if = 1'b0;
        step();
        n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL wb_read_bubble: got %b exp 0", valid_id); end
    endtask

    task automatic test_imm();
        valid_if = 1'b1; IR_if = mk_ir(6'h02, 5'd2, 5'd0, 16'h8000);
        step();
        n_checks++; if (Imm !== 32'hFFFF8000) begin n_fail++; $display("FAIL imm_neg: got %h exp ffff8000", Imm); end
        // rs2 field of 0x8000 is r16, never written, so B reads 0.
        n_checks++; if (B !== 32'h0) begin n_fail++; $display("FAIL imm_neg_B: got %h exp 0", B); end
        IR_if = mk_ir(6'h02, 5'd2, 5'd0, 16'h7FFF);
        step();
        n_checks++; if (Imm !== 32'h00007FFF) begin n_fail++; $display("FAIL imm_pos: got %h exp 00007fff", Imm); end
        valid_if = 1'b0;
        step();
    endtask

    task automatic test_hold();
        logic [31:0] ir1, ir2;
        ir1 = mk_ir(6'h03, 5'd4, 5'd3, 16'h2800);
        ir2 = mk_ir(6'h04, 5'd6, 5'd5, 16'h0001);
        ready_ex = 1'b0; valid_if = 1'b1; IR_if = ir1; NPC_if = 32'h200;
        step();
        n_checks++; if (ready_id !== 1'b0) begin n_fail++; $display("FAIL hold_ready: got %b exp 0", ready_id); end
        IR_if = ir2; NPC_if = 32'h204;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (IR_id !== ir1 || A !== 32'h1234 || NPC_id !== 32'h200 || valid_id !== 1'b1) begin
                n_fail++; $display("FAIL hold_frozen[%0d]: got IR %h A %h NPC %h v %b exp IR %h A 1234 NPC 200 v 1",
                                   i, IR_id, A, NPC_id, valid_id, ir1);
            end
        end
        ready_ex = 1'b1;
        #1;
        n_checks++; if (ready_id !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready: got %b exp 1", ready_id); end
        step();
        n_checks++; if (IR_id !== ir2 || A !== 32'h55) begin
            n_fail++; $display("FAIL hold_next: got IR %h A %h exp IR %h A 55", IR_id, A, ir2);
        end
        valid_if = 1'b0;
        step();
    endtask

    task automatic test_flush();
        logic [31:0] ira, irb;
        ira = mk_ir(6'h05, 5'd1, 5'd3, 16'h0010);
        irb = mk_ir(6'h06, 5'd2, 5'd5, 16'h0020);
        ready_ex = 1'b0; valid_if = 1'b1; IR_if = ira;
        step();
        n_checks++; if (valid_id !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %b exp 1", valid_id); end
        flush = 1'b1; IR_if = irb;
        step();
        flush = 1'b0;
        n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b exp 0", valid_id); end
        n_checks++; if (IR_id !== ira) begin n_fail++; $display("FAIL flush_no_capture: got %h exp %h", IR_id, ira); end
        n_checks++; if (ready_id !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b exp 1", ready_id); end
        ready_ex = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b exp 0", valid_id); end
        valid_if = 1'b0;
        step();
    endtask

    task automatic test_bypass();
        logic [31:0] exp_a;
        wb_write(5'd7, 32'h11);
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hAA;
        valid_if = 1'b1; IR_if = mk_ir(6'h07, 5'd1, 5'd7, 16'h0000);
`ifdef DECODE_WB_BYPASS_EN
        exp_a = 32'hAA;
`else
        exp_a = 32'h11;
`endif
        step();
        wb_en = 1'b0;
        n_checks++; if (A !== exp_a) begin n_fail++; $display("FAIL bypass_same_cycle: got %h exp %h", A, exp_a); end
        step();
        n_checks++; if (A !== 32'hAA) begin n_fail++; $display("FAIL bypass_after: got %h exp aa", A); end
        valid_if = 1'b0;
        wb_write(5'd0, 32'hDEAD);
        valid_if = 1'b1; IR_if = mk_ir(6'h08, 5'd1, 5'd0, 16'h0000);
        step();
        n_checks++; if (A !== 32'h0 || B !== 32'h0) begin
            n_fail++; $display("FAIL r0_write_ignored: got A %h B %h exp 0 0", A, B);
        end
        valid_if = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        ready_ex = 1'b0; valid_if = 1'b1; IR_if = mk_ir(6'h09, 5'd2, 5'd5, 16'h8001); NPC_if = 32'h300;
        step();
        n_checks++; if (valid_id !== 1'b1 || A !== 32'h55) begin
            n_fail++; $display("FAIL mid_pre: got v %b A %h exp v 1 A 55", valid_id, A);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (valid_id !== 1'b0 || A !== 32'h0 || B !== 32'h0 || Imm !== 32'h0 || IR_id !== 32'h0 || NPC_id !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_async: got v %b A %h B %h Imm %h IR %h NPC %h exp all 0",
                               valid_id, A, B, Imm, IR_id, NPC_id);
        end
        step();
        rst_n = 1'b1; ready_ex = 1'b1;
        step();
        n_checks++; if (A !== 32'h0 || valid_id !== 1'b1) begin
            n_fail++; $display("FAIL mid_r5_cleared: got A %h v %b exp A 0 v 1", A, valid_id);
        end
        valid_if = 1'b0;
        step();
    endtask

    initial begin
        #1;
        test_reset();
        test_wb_read();
        test_imm();
        test_hold();
        test_flush();
        test_bypass();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
